// File: rtl/video_rx_timing.sv
// Sink-side video timing monitor.
// Recovers pixel coordinates from a registered vde/vsync/rgb stream, reduces
// the colour to one bit per channel, measures the active width and height,
// and runs a lock FSM that flags timing instability.

module video_rx_timing #(
    parameter bit VSYNC_ACTIVE_HIGH = 1'b0,
    parameter int CW                = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hsync,
    input  logic          vsync,
    input  logic          vde,
    input  logic [23:0]   rgb,
    output logic          pix_valid,
    output logic [CW-1:0] pix_x,
    output logic [CW-1:0] pix_y,
    output logic [2:0]    pix_rgb3,
    output logic          frame_start,
    output logic [CW-1:0] line_width,
    output logic [CW-1:0] frame_height,
    output logic          locked,
    output logic          timing_err
);

    localparam logic [CW-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        ACQUIRE  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    // Two-deep input pipeline; only the colour MSBs are needed downstream.
    logic          hs_s1, hs_s2;
    logic          vs_s1, vs_s2;
    logic          de_s1, de_s2;
    logic [2:0]    rgb3_s1;

    // Coordinate counters and per-frame bookkeeping.
    logic [CW-1:0] x_cnt;
    logic [CW-1:0] y_cnt;
    logic [CW-1:0] first_w;
    logic          have_first;
    logic          frame_bad;

    // Lock state and the stored reference geometry.
    state_t        state;
    logic [CW-1:0] ref_w;
    logic [CW-1:0] ref_h;
    logic          ref_valid;

    // Event decode from the two pipeline stages.
    logic          vs_on1, vs_on2;
    logic          vs_lead, de_rise, de_fall;
    logic [CW-1:0] w_now;
    logic [CW-1:0] y_inc;
    logic [CW-1:0] height;
    logic [CW-1:0] first_now;
    logic          bad_now;

    // hsync is carried through the pipeline for future checks only; the low
    // colour bits are intentionally discarded.
    logic          unused_bits;
    assign unused_bits = ^{hs_s2, rgb[22:16], rgb[14:8], rgb[6:0]};

    assign vs_on1  = VSYNC_ACTIVE_HIGH ? vs_s1 : ~vs_s1;
    assign vs_on2  = VSYNC_ACTIVE_HIGH ? vs_s2 : ~vs_s2;
    assign vs_lead = vs_on1 & ~vs_on2;
    assign de_rise = de_s1 & ~de_s2;
    assign de_fall = ~de_s1 & de_s2;

    // Width of the line that is ending now, and the bumped line count.
    assign w_now = (x_cnt == CNT_MAX) ? CNT_MAX : x_cnt + 1'b1;
    assign y_inc = (y_cnt == CNT_MAX) ? CNT_MAX : y_cnt + 1'b1;

    // A line ending in the same cycle as the frame boundary still belongs
    // to the closing frame, so fold it into height, first width and badness.
    assign height    = de_fall ? y_inc : y_cnt;
    assign first_now = (de_fall && !have_first) ? w_now : first_w;
    assign bad_now   = frame_bad | (de_fall & have_first & (w_now != first_w));

    assign pix_x        = x_cnt;
    assign pix_y        = y_cnt;
    assign line_width   = ref_w;
    assign frame_height = ref_h;

    // Register the incoming stream twice for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs_s1   <= 1'b0;
            hs_s2   <= 1'b0;
            vs_s1   <= 1'b0;
            vs_s2   <= 1'b0;
            de_s1   <= 1'b0;
            de_s2   <= 1'b0;
            rgb3_s1 <= 3'b000;
        end else begin
            hs_s1   <= hsync;
            hs_s2   <= hs_s1;
            vs_s1   <= vsync;
            vs_s2   <= vs_s1;
            de_s1   <= vde;
            de_s2   <= de_s1;
            rgb3_s1 <= {rgb[7], rgb[15], rgb[23]};
        end
    end

    // Pixel output stage, coordinate counters and frame-start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_valid   <= 1'b0;
            pix_rgb3    <= 3'b000;
            frame_start <= 1'b0;
            x_cnt       <= '0;
            y_cnt       <= '0;
        end else begin
            pix_valid   <= de_s1;
            pix_rgb3    <= rgb3_s1;
            frame_start <= vs_lead;
            if (de_rise) begin
                x_cnt <= '0;
            end else if (de_s1 && x_cnt != CNT_MAX) begin
                x_cnt <= x_cnt + 1'b1;
            end
            if (vs_lead) begin
                y_cnt <= '0;
            end else if (de_fall) begin
                y_cnt <= y_inc;
            end
        end
    end

    // Track the first line width of a frame and whether any line differed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_w    <= '0;
            have_first <= 1'b0;
            frame_bad  <= 1'b0;
        end else if (vs_lead) begin
            first_w    <= '0;
            have_first <= 1'b0;
            frame_bad  <= 1'b0;
        end else if (de_fall) begin
            if (!have_first) begin
                first_w    <= w_now;
                have_first <= 1'b1;
            end else if (w_now != first_w) begin
                frame_bad <= 1'b1;
            end
        end
    end

    // Lock FSM: learn a reference frame, confirm it, then police it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= UNLOCKED;
            ref_w      <= '0;
            ref_h      <= '0;
            ref_valid  <= 1'b0;
            locked     <= 1'b0;
            timing_err <= 1'b0;
        end else begin
            timing_err <= 1'b0;
            case (state)
                UNLOCKED: begin
                    if (vs_lead) begin
                        state     <= ACQUIRE;
                        ref_valid <= 1'b0;
                    end
                end
                ACQUIRE: begin
                    if (vs_lead) begin
                        if (bad_now || height == '0) begin
                            ref_valid <= 1'b0;
                        end else if (ref_valid && first_now == ref_w && height == ref_h) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end else begin
                            ref_w     <= first_now;
                            ref_h     <= height;
                            ref_valid <= 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if ((de_fall && w_now != ref_w) || (vs_lead && height != ref_h)) begin
                        timing_err <= 1'b1;
                        locked     <= 1'b0;
                        state      <= UNLOCKED;
                    end
                end
                default: begin
                    state  <= UNLOCKED;
                    locked <= 1'b0;
                end
            endcase
        end
    end

endmodule
